// File: rtl/pe_row_ctrl.sv
// pe_row_ctrl: sequencer driving one PE in 1-D row convolution mode with a 3-tap kernel.
// Define PE_ROW_CTRL_PERF_EN to add the stall_cnt performance counter output.
module pe_row_ctrl #(
  parameter int ROW_W    = 8,
  parameter int ROWS_W   = 8,
  parameter int PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ROW_W-1:0]  cfg_row_len,
  input  logic [ROWS_W-1:0] cfg_num_rows,
  input  logic              filt_valid,
  output logic              filt_ready,
  input  logic [11:0]       filt_data,
  input  logic              ifmap_valid,
  output logic              ifmap_ready,
  input  logic [7:0]        ifmap_data,
  output logic              pe_en,
  output logic [11:0]       pe_filtr,
  output logic [7:0]        pe_ifmap,
  output logic [13:0]       pe_psum_in,
  input  logic [13:0]       pe_psum_out,
  output logic              psum_valid,
  input  logic              psum_ready,
  output logic [13:0]       psum_data,
  output logic              busy,
  output logic              done
`ifdef PE_ROW_CTRL_PERF_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_FILT,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int TAG_N = PIPE_LAT - 1;
  localparam int DRN_W = $clog2(PIPE_LAT) + 1;
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(PIPE_LAT - 1);

  state_t             r_state;
  state_t             w_next;
  logic [ROW_W-1:0]   r_row_len;
  logic [ROWS_W-1:0]  r_num_rows;
  logic [ROW_W-1:0]   r_pix_cnt;
  logic [ROWS_W-1:0]  r_row_cnt;
  logic [DRN_W-1:0]   r_drn_cnt;
  logic [11:0]        r_filt;
  logic [TAG_N-1:0]   r_tag;
  logic               r_psum_valid;
  logic               w_adv;
  logic               w_tag_in;
  logic               w_last_pix;
  logic               w_rows_left;
  logic               w_drain_busy;

  assign w_adv        = !r_psum_valid || psum_ready;
  assign w_last_pix   = (r_pix_cnt == r_row_len - ROW_W'(1));
  assign w_rows_left  = (r_row_cnt != r_num_rows - ROWS_W'(1));
  assign w_drain_busy = (r_drn_cnt != DRN_LAST);

  assign pe_filtr   = r_filt;
  assign pe_psum_in = '0;
  assign psum_valid = r_psum_valid;
  assign psum_data  = pe_psum_out;
  assign busy       = (r_state != S_IDLE);

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    w_next      = r_state;
    filt_ready  = 1'b0;
    ifmap_ready = 1'b0;
    pe_en       = 1'b0;
    pe_ifmap    = '0;
    w_tag_in    = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start)
          w_next = (cfg_row_len < ROW_W'(3) || cfg_num_rows == '0) ? S_DONE : S_LOAD_FILT;
      end
      S_LOAD_FILT: begin
        filt_ready = 1'b1;
        if (filt_valid) w_next = S_STREAM;
      end
      S_STREAM: begin
        ifmap_ready = w_adv;
        pe_en       = ifmap_valid && w_adv;
        pe_ifmap    = ifmap_data;
        // Only windows lying wholly inside the current row are tagged.
        w_tag_in    = (r_pix_cnt >= ROW_W'(2));
        if (pe_en && w_last_pix) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_drain_busy)      pe_en  = w_adv;
        else if (w_rows_left)  w_next = S_STREAM;
        else if (!r_psum_valid) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_len  <= '0;
      r_num_rows <= '0;
      r_pix_cnt  <= '0;
      r_row_cnt  <= '0;
      r_drn_cnt  <= '0;
      r_filt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_row_len  <= cfg_row_len;
            r_num_rows <= cfg_num_rows;
          end
        end
        S_LOAD_FILT: begin
          if (filt_valid) begin
            r_filt    <= filt_data;
            r_pix_cnt <= '0;
            r_row_cnt <= '0;
          end
        end
        S_STREAM: begin
          if (pe_en) begin
            r_pix_cnt <= r_pix_cnt + ROW_W'(1);
            if (w_last_pix) r_drn_cnt <= '0;
          end
        end
        S_DRAIN: begin
          if (pe_en) begin
            r_drn_cnt <= r_drn_cnt + DRN_W'(1);
          end else if (!w_drain_busy && w_rows_left) begin
            r_pix_cnt <= '0;
            r_row_cnt <= r_row_cnt + ROWS_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the tag flops are reset too, so an aborted job can never leak a stale valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag        <= '0;
      r_psum_valid <= 1'b0;
    end else if (pe_en) begin
      r_tag[0] <= w_tag_in;
      for (int i = 1; i < TAG_N; i++) r_tag[i] <= r_tag[i-1];
      r_psum_valid <= r_tag[TAG_N-1];
    end else if (r_psum_valid && psum_ready) begin
      r_psum_valid <= 1'b0;
    end
  end

`ifdef PE_ROW_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = (r_state == S_STREAM || r_state == S_DRAIN) &&
                   ((ifmap_valid && !w_adv) || (r_psum_valid && !psum_ready));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_stall_cnt <= '0;
    else if (r_state == S_IDLE && start) r_stall_cnt <= '0;
    else if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
